ring_arbiter: RTL and testbench

Round-robin arbiter that shares one resource, such as the LED/display bus driven by the lab ring-counter datapath, among N requesters. Priority is held in a one-hot ring register that rotates past each winner, so every requester gets fair access. Grants are registered and one-hot. A hold timer forces release when an owner exceeds its slot. It sits between requesting sub-blocks and the shared resource's mux select.

---
 rtl/ring_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_ring_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ring_arbiter.sv
// ring_arbiter
//
// Round-robin arbiter that shares one resource among N requesters. A one-hot
// priority ring (o_ptr) marks the highest-priority requester and is rotated to
// the position just past each winner, so every requester gets fair access.
// Grants are registered and one-hot. A hold counter forces release when an
// owner keeps its grant for HOLD_MAX cycles. Every grant is followed by exactly
// one idle (bubble) cycle, so ownership of the shared resource never overlaps.
//
// Parameters:
//   N         number of requesters (N >= 2)
//   HOLD_MAX  maximum consecutive cycles one grant may be held (>= 1)
//   IW        width of o_gnt_id
//   CW        width of the hold counter (minimum 1)
//
// Ports:
//   i_clk        system clock, all state updates on the rising edge
//   i_rst        asynchronous, active-high reset
//   i_req        request lines, bit k = requester k
//   i_release    current owner finished, sampled only while granting
//   o_gnt        registered one-hot grant, all-zero when idle
//   o_gnt_valid  high whenever o_gnt is non-zero
//   o_gnt_id     binary index of the granted bit, 0 when idle
//   o_ptr        one-hot priority ring, set bit = highest-priority requester
//   o_timeout    one-cycle pulse in the bubble that follows a forced release

module ring_arbiter #(
  parameter int N        = 8,
  parameter int HOLD_MAX = 16,
  parameter int IW       = $clog2(N),
  parameter int CW       = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_release,
  output logic [N-1:0]  o_gnt,
  output logic          o_gnt_valid,
  output logic [IW-1:0] o_gnt_id,
  output logic [N-1:0]  o_ptr,
  output logic          o_timeout
);

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  state_t          r_state;
  logic [N-1:0]    r_gnt;
  logic            r_gnt_valid;
  logic [IW-1:0]   r_gnt_id;
  logic [N-1:0]    r_ptr;
  logic [CW-1:0]   r_cnt;
  logic            r_timeout;

  // Next-state values
  state_t          w_state_next;
  logic [N-1:0]    w_gnt_next;
  logic            w_gnt_valid_next;
  logic [IW-1:0]   w_gnt_id_next;
  logic [N-1:0]    w_ptr_next;
  logic [CW-1:0]   w_cnt_next;
  logic            w_timeout_next;

  // Arbitration datapath
  logic [IW-1:0]   w_ptr_idx;
  logic [N-1:0]    w_req_rot;
  logic            w_win_found;
  logic [IW-1:0]   w_win_off;
  logic [IW:0]     w_win_sum;
  logic [IW-1:0]   w_win_idx;
  logic [N-1:0]    w_win_onehot;
  logic [N-1:0]    w_win_ptr;

  // Grant-exit conditions
  logic            w_owner_req;
  logic            w_hold_last;

  // ---------------------------------------------------------------------------
  // Round-robin selection
  // ---------------------------------------------------------------------------

  // Binary position of the priority pointer.
  always_comb begin
    w_ptr_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (r_ptr[i]) begin
        w_ptr_idx = IW'(i);
      end
    end
  end

  // Rotate the requests right so the pointer position lands on bit 0; the
  // lowest set bit of the rotated vector is then the wrap-around winner.
  assign w_req_rot = N'({i_req, i_req} >> w_ptr_idx);

  always_comb begin
    w_win_found = 1'b0;
    w_win_off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_req_rot[i]) begin
        w_win_found = 1'b1;
        w_win_off   = IW'(i);
      end
    end
  end

  // Undo the rotation: winner = (ptr + offset) mod N.
  assign w_win_sum = {1'b0, w_ptr_idx} + {1'b0, w_win_off};
  assign w_win_idx = IW'((w_win_sum >= (IW + 1)'(N)) ? (w_win_sum - (IW + 1)'(N)) : w_win_sum);

  assign w_win_onehot = {{(N - 1){1'b0}}, 1'b1} << w_win_idx;

  // Priority moves to the requester just past the winner.
  assign w_win_ptr = {w_win_onehot[N-2:0], w_win_onehot[N-1]};

  // ---------------------------------------------------------------------------
  // Grant-exit conditions
  // ---------------------------------------------------------------------------

  // Only the owner's request bit matters; other bits are ignored while granted.
  assign w_owner_req = |(i_req & r_gnt);
  assign w_hold_last = (r_cnt == CW'(HOLD_MAX - 1));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next     = r_state;
    w_gnt_next       = r_gnt;
    w_gnt_valid_next = r_gnt_valid;
    w_gnt_id_next    = r_gnt_id;
    w_ptr_next       = r_ptr;
    w_cnt_next       = r_cnt;
    w_timeout_next   = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_win_found) begin
          w_state_next     = StGrant;
          w_gnt_next       = w_win_onehot;
          w_gnt_valid_next = 1'b1;
          w_gnt_id_next    = w_win_idx;
          w_ptr_next       = w_win_ptr;
          w_cnt_next       = '0;
        end
      end

      StGrant: begin
        if (i_release || !w_owner_req || w_hold_last) begin
          w_state_next     = StIdle;
          w_gnt_next       = '0;
          w_gnt_valid_next = 1'b0;
          w_gnt_id_next    = '0;
          w_cnt_next       = '0;
          // A forced exit is flagged only if neither normal exit applies.
          w_timeout_next   = !i_release && w_owner_req;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end

      default: begin
        w_state_next     = StIdle;
        w_gnt_next       = '0;
        w_gnt_valid_next = 1'b0;
        w_gnt_id_next    = '0;
        w_cnt_next       = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= '0;
      r_ptr       <= {{(N - 1){1'b0}}, 1'b1};
      r_cnt       <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_gnt       <= w_gnt_next;
      r_gnt_valid <= w_gnt_valid_next;
      r_gnt_id    <= w_gnt_id_next;
      r_ptr       <= w_ptr_next;
      r_cnt       <= w_cnt_next;
      r_timeout   <= w_timeout_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_gnt       = r_gnt;
  assign o_gnt_valid = r_gnt_valid;
  assign o_gnt_id    = r_gnt_id;
  assign o_ptr       = r_ptr;
  assign o_timeout   = r_timeout;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_gnt_onehot0 : assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(r_gnt));
  a_ptr_onehot  : assert property (@(posedge i_clk) disable iff (i_rst) $onehot(r_ptr));
  a_valid_match : assert property (@(posedge i_clk) disable iff (i_rst)
                                   r_gnt_valid == (|r_gnt));
  a_timeout_gap : assert property (@(posedge i_clk) disable iff (i_rst)
                                   r_timeout |-> (r_gnt == '0));
`endif

endmodule

// File: tb/tb_ring_arbiter.sv
// Self-checking bench for ring_arbiter (N=8, HOLD_MAX=16).
// A table of {req, release, expected gnt, expected ptr, expected timeout}
// records is applied one clock per record; expectations are queued when the
// stimulus is driven and popped/compared one edge later. Hand-written
// sequences cover reset at start-up and asynchronous reset mid-grant.

module tb_ring_arbiter;

  localparam int N        = 8;
  localparam int HOLD_MAX = 16;
  localparam int IW       = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic          rel;
  logic [N-1:0]  gnt;
  logic          gnt_valid;
  logic [IW-1:0] gnt_id;
  logic [N-1:0]  ptr;
  logic          timeout;

  ring_arbiter #(
    .N        (N),
    .HOLD_MAX (HOLD_MAX)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_release   (rel),
    .o_gnt       (gnt),
    .o_gnt_valid (gnt_valid),
    .o_gnt_id    (gnt_id),
    .o_ptr       (ptr),
    .o_timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       rel;
    logic [7:0] gnt;
    logic [7:0] ptr;
    logic       to;
  } vec_t;

  typedef struct {
    logic [7:0] gnt;
    logic [7:0] ptr;
    logic       to;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [2:0] idx_of(input logic [7:0] oh);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) r = 3'(i);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] r, input logic rl, input logic [7:0] g,
                     input logic [7:0] p, input logic t);
    vec_t v;
    v.req = r;
    v.rel = rl;
    v.gnt = g;
    v.ptr = p;
    v.to  = t;
    vecs.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] eg, input logic [7:0] ep,
                               input logic et);
    check({tag, ".gnt"},       32'(gnt),       32'(eg));
    check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(eg != 8'h00));
    check({tag, ".gnt_id"},    32'(gnt_id),    32'(idx_of(eg)));
    check({tag, ".ptr"},       32'(ptr),       32'(ep));
    check({tag, ".timeout"},   32'(timeout),   32'(et));
  endtask

  // Drive one cycle of stimulus and compare the registered result after the edge.
  task automatic step(input logic [7:0] r, input logic rl, input logic [7:0] eg,
                      input logic [7:0] ep, input logic et, input string tag);
    exp_t e;
    @(negedge clk);
    req   = r;
    rel   = rl;
    e.gnt = eg;
    e.ptr = ep;
    e.to  = et;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s.scoreboard: got empty queue, expected one entry", tag);
    end else begin
      e = sb.pop_front();
      check_outputs(tag, e.gnt, e.ptr, e.to);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected $finish before 100000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req = 8'h00;
    rel = 1'b0;

    // Full rotation with all requesters active, release on each grant's first cycle.
    for (int k = 0; k < 8; k++) begin
      add(8'hFF, 1'b0, 8'(1 << k), 8'(1 << ((k + 1) % 8)), 1'b0);
      add(8'hFF, 1'b1, 8'h00,      8'(1 << ((k + 1) % 8)), 1'b0);
    end
    add(8'hFF, 1'b0, 8'h01, 8'h02, 1'b0);
    add(8'hFF, 1'b1, 8'h00, 8'h02, 1'b0);

    // Wrap search from ptr=0x02.
    add(8'h81, 1'b0, 8'h80, 8'h01, 1'b0);
    add(8'h81, 1'b1, 8'h00, 8'h01, 1'b0);
    add(8'h81, 1'b0, 8'h01, 8'h02, 1'b0);
    add(8'h81, 1'b1, 8'h00, 8'h02, 1'b0);

    // Implicit release: other bits toggle harmlessly, then req[3] drops.
    add(8'h08, 1'b0, 8'h08, 8'h10, 1'b0);
    add(8'h0F, 1'b0, 8'h08, 8'h10, 1'b0);
    add(8'h07, 1'b0, 8'h00, 8'h10, 1'b0);
    add(8'h00, 1'b0, 8'h00, 8'h10, 1'b0);

    // Forced release after exactly HOLD_MAX grant cycles, then re-grant.
    add(8'h04, 1'b0, 8'h04, 8'h08, 1'b0);
    for (int i = 0; i < HOLD_MAX - 1; i++) add(8'h04, 1'b0, 8'h04, 8'h08, 1'b0);
    add(8'h04, 1'b0, 8'h00, 8'h08, 1'b1);
    add(8'h04, 1'b0, 8'h04, 8'h08, 1'b0);

    // Release on the last allowed cycle wins over the timeout.
    for (int i = 0; i < HOLD_MAX - 1; i++) add(8'h04, 1'b0, 8'h04, 8'h08, 1'b0);
    add(8'h04, 1'b1, 8'h00, 8'h08, 1'b0);

    // Release is ignored while idle; dropping the owner's request ends the grant.
    add(8'h04, 1'b1, 8'h04, 8'h08, 1'b0);
    add(8'h00, 1'b0, 8'h00, 8'h08, 1'b0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 8'h00, 8'h01, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].req, vecs[i].rel, vecs[i].gnt, vecs[i].ptr, vecs[i].to,
           $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of a grant, between clock edges.
    step(8'h20, 1'b0, 8'h20, 8'h40, 1'b0, "pre_rst");
    #1;
    rst = 1'b1;
    req = 8'h00;
    #1;
    check_outputs("async_rst", 8'h00, 8'h01, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // First grant after reset scans from ptr=0x01.
    step(8'hFF, 1'b0, 8'h01, 8'h02, 1'b0, "post_rst_grant");
    step(8'hFF, 1'b1, 8'h00, 8'h02, 1'b0, "post_rst_release");

    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
